dror_validator_stream: RTL and testbench
========================================

DROR_VALIDATOR_STREAM -- requirements
Module: dror_validator_stream

Interface
REQ-001 SHALL have parameter N, default 16, signed coordinate width.
REQ-002 SHALL have parameter LANES, default 8, candidates compared per beat (1..32).
REQ-003 SHALL have parameter CNT_W, default 16, width of cloud-size, threshold and neighbour counters.
REQ-004 SHALL have parameter ANG_SHIFT, default 3, radius = planar range >> ANG_SHIFT.
REQ-005 SHALL have ports: i_clock in 1 clock; i_reset in 1 reset (one clock; reset is synchronous and active-high).
REQ-006 SHALL have query ports: i_q_valid in 1; o_q_ready out 1; i_q_x, i_q_y, i_q_z in N each, query point.
REQ-007 SHALL have config ports: i_cloud_size in CNT_W; i_threshold in CNT_W; i_min_radius in N (unsigned); all sampled at query accept.
REQ-008 SHALL have candidate ports: i_cand_valid in 1; o_cand_ready out 1; i_cand_x, i_cand_y, i_cand_z in N*LANES each, lane k at bits [(k+1)*N-1:k*N].
REQ-009 SHALL have result ports: o_res_valid out 1; i_res_ready in 1; o_inlier out 1; o_outlier out 1.

Function
REQ-010 SHALL implement FSM IDLE -> RADIUS -> COMPARE -> DRAIN -> DONE -> IDLE.
REQ-011 IDLE: o_q_ready=1; on i_q_valid&&o_q_ready latch query and config, go RADIUS.
REQ-012 RADIUS (1 cycle): r2 = max(i_min_radius^2, (x^2+y^2) >> (2*ANG_SHIFT)), unsigned 2N+2 bits, no square root.
REQ-013 COMPARE: o_cand_ready=1; accepted beat = i_cand_valid&&o_cand_ready.
REQ-014 Per beat, only the first min(LANES, remaining) lanes are valid; remaining = cloud_size - points accepted so far.
REQ-015 Each valid lane computes d2 = dx^2+dy^2+dz^2 at 2N+2 bits, sign-extended differences, no overflow.
REQ-016 Lane counts as neighbour iff d2 <= r2; a candidate identical to the query counts.
REQ-017 Compare pipeline latency fixed at 2 cycles from beat accept to counter update.
REQ-018 Neighbour counter adds the popcount of matching lanes per beat, saturating at 2^CNT_W-1.
REQ-019 On accepting the beat that exhausts cloud_size, deassert o_cand_ready next cycle and go DRAIN for 2 cycles.
REQ-020 cloud_size==0: RADIUS goes directly to DONE; no candidate beats accepted.
REQ-021 DONE: o_res_valid=1, o_inlier=(count>=threshold), o_outlier=!o_inlier, held stable until i_res_ready.
REQ-022 threshold==0 SHALL yield o_inlier=1 regardless of candidates.
REQ-023 On i_res_ready in DONE, clear counters, return to IDLE; o_res_valid low next cycle.
REQ-024 o_inlier and o_outlier SHALL be 0 whenever o_res_valid=0; never both 1.
REQ-025 o_q_ready=0 and o_cand_ready=0 outside IDLE and COMPARE respectively.

Reset
REQ-026 i_reset sampled at i_clock rising edge SHALL force IDLE, clear counters and pipeline valids.
REQ-027 Reset values: o_q_ready=1 in the cycle after reset, o_cand_ready=0, o_res_valid=0, o_inlier=0, o_outlier=0.
REQ-028 Reset mid-COMPARE or mid-DRAIN SHALL discard the query; in-flight lane results SHALL NOT reach the counter.

Configuration
REQ-029 Macro DROR_STATS_EN defined: add output o_neighbor_count, CNT_W bits, final saturated count, valid with o_res_valid, otherwise 0.
REQ-030 Macro DROR_STATS_EN undefined: port o_neighbor_count absent; all other behaviour identical.

Structure
REQ-031 Package dror_pkg SHALL hold the FSM state enum, the COMPARE_LAT=2 constant and the d2 width function (2N+2).
REQ-032 Sub-module dror_dist2_lane SHALL compute the registered 2-stage d2 and compare for one lane; instantiated LANES times.

Verification
REQ-033 LANES=8, query (0,0,0), min_radius=2, cloud_size=8, threshold=3, one beat, three lanes at (1,1,0), rest at (100,0,0) -> o_res_valid, o_inlier=1.
REQ-034 Query (800,0,0), ANG_SHIFT=3 (r2=10000), cloud_size=20, threshold=5, three beats with four points at dx=100 and one at dx=101 -> count 4, o_outlier=1; lanes 4..7 of beat 3 carry dx=0 and are ignored.
REQ-035 cloud_size=0, threshold=1 -> no o_cand_ready pulse, o_outlier=1 within 3 cycles of query accept; threshold=0 -> o_inlier=1.
REQ-036 i_res_ready held low 10 cycles -> result and o_res_valid stable; the next query is not accepted until handshake.
REQ-037 i_reset asserted during the 2nd COMPARE beat -> outputs at reset values next cycle; the following query result is unaffected by stale lanes.
REQ-038 Negative coordinates: query (-5,-5,-5), candidate (5,5,5), r2 covering 300 -> counted; r2=299 -> not counted.

Source files
------------

// File: rtl/dror_pkg.sv
// Shared types and constants for the DROR neighbour-count validator.
// The FSM state encoding, compare pipeline depth and squared-distance width live here.
package dror_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADIUS,
        S_COMPARE,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam int COMPARE_LAT = 2;

    // Three squared (N+1)-bit differences summed never exceed 2N+2 bits.
    function automatic int d2_width(input int n);
        return 2 * n + 2;
    endfunction

endpackage

// File: rtl/dror_dist2_lane.sv
// One candidate lane: squares the three sign-extended differences, then sums
// and compares against r2, producing a registered match two cycles after i_valid.
module dror_dist2_lane
    import dror_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic signed [N-1:0]      i_q_x,
    input  logic signed [N-1:0]      i_q_y,
    input  logic signed [N-1:0]      i_q_z,
    input  logic signed [N-1:0]      i_c_x,
    input  logic signed [N-1:0]      i_c_y,
    input  logic signed [N-1:0]      i_c_z,
    input  logic [d2_width(N)-1:0]   i_r2,
    output logic                     o_match
);

    localparam int D2W = d2_width(N);

    logic signed [D2W-1:0] dx_w, dy_w, dz_w;
    logic [D2W-1:0]        sq_x_d, sq_y_d, sq_z_d;
    logic [D2W-1:0]        sq_x_q, sq_y_q, sq_z_q;
    logic [D2W-1:0]        sum_w;
    logic                  valid_q, match_q;

    assign dx_w   = D2W'(i_q_x) - D2W'(i_c_x);
    assign dy_w   = D2W'(i_q_y) - D2W'(i_c_y);
    assign dz_w   = D2W'(i_q_z) - D2W'(i_c_z);
    assign sq_x_d = dx_w * dx_w;
    assign sq_y_d = dy_w * dy_w;
    assign sq_z_d = dz_w * dz_w;
    assign sum_w  = sq_x_q + sq_y_q + sq_z_q;

    // NOTE: only the valid/match bits need reset; squares are qualified by valid_q,
    // so leaving the wide datapath unreset is safe and keeps the reset tree small.
    always_ff @(posedge i_clock) begin
        sq_x_q <= sq_x_d;
        sq_y_q <= sq_y_d;
        sq_z_q <= sq_z_d;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            valid_q <= i_valid;
            match_q <= valid_q && (sum_w <= i_r2);
        end
    end

    assign o_match = match_q;

endmodule

// File: rtl/dror_validator_stream.sv
// DROR outlier validator: counts cloud points within a range-dependent radius of a query.
// Optional macro DROR_STATS_EN adds o_neighbor_count carrying the final saturated count.
module dror_validator_stream
    import dror_pkg::*;
#(
    parameter int N         = 16,
    parameter int LANES     = 8,
    parameter int CNT_W     = 16,
    parameter int ANG_SHIFT = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_q_valid,
    output logic                 o_q_ready,
    input  logic [N-1:0]         i_q_x,
    input  logic [N-1:0]         i_q_y,
    input  logic [N-1:0]         i_q_z,
    input  logic [CNT_W-1:0]     i_cloud_size,
    input  logic [CNT_W-1:0]     i_threshold,
    input  logic [N-1:0]         i_min_radius,
    input  logic                 i_cand_valid,
    output logic                 o_cand_ready,
    input  logic [N*LANES-1:0]   i_cand_x,
    input  logic [N*LANES-1:0]   i_cand_y,
    input  logic [N*LANES-1:0]   i_cand_z,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic                 o_inlier,
    output logic                 o_outlier
`ifdef DROR_STATS_EN
    ,
    output logic [CNT_W-1:0]     o_neighbor_count
`endif
);

    localparam int             D2W     = d2_width(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                 state_q;
    logic                   q_ready_q, cand_ready_q, res_valid_q, inlier_q, outlier_q;
    logic signed [N-1:0]    qx_q, qy_q, qz_q;
    logic [N-1:0]           min_r_q;
    logic [CNT_W-1:0]       thr_q, rem_q, count_q, count_d;
    logic [D2W-1:0]         r2_q;
    logic [1:0]             drain_q;
    logic                   beat_acc, last_beat;
    logic [LANES-1:0]       lane_valid, lane_match;
    logic [CNT_W+5:0]       sum_c;

    // Radius squared: max(min_radius^2, planar range^2 scaled down by the angular step).
    logic signed [D2W-1:0]  qx_e, qy_e;
    logic [D2W-1:0]         px2_w, py2_w, pr2_w, mr2_w, r2_d;

    assign qx_e  = D2W'(qx_q);
    assign qy_e  = D2W'(qy_q);
    assign px2_w = qx_e * qx_e;
    assign py2_w = qy_e * qy_e;
    assign pr2_w = (px2_w + py2_w) >> (2 * ANG_SHIFT);
    assign mr2_w = D2W'(min_r_q) * D2W'(min_r_q);
    assign r2_d  = (mr2_w > pr2_w) ? mr2_w : pr2_w;

    assign beat_acc  = i_cand_valid && cand_ready_q;
    assign last_beat = 64'(rem_q) <= 64'(LANES);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_valid[k] = beat_acc && (64'(k) < 64'(rem_q));

        dror_dist2_lane #(.N(N)) u_lane (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_valid (lane_valid[k]),
            .i_q_x   (qx_q),
            .i_q_y   (qy_q),
            .i_q_z   (qz_q),
            .i_c_x   (i_cand_x[k*N +: N]),
            .i_c_y   (i_cand_y[k*N +: N]),
            .i_c_z   (i_cand_z[k*N +: N]),
            .i_r2    (r2_q),
            .o_match (lane_match[k])
        );
    end

    // NOTE: every variable written here gets a value before any condition,
    // otherwise the tool infers a latch.
    always_comb begin
        sum_c = {6'b0, count_q};
        for (int k = 0; k < LANES; k++) begin
            sum_c = sum_c + (CNT_W+6)'(lane_match[k]);
        end
        count_d = (sum_c > {6'b0, CNT_MAX}) ? CNT_MAX : sum_c[CNT_W-1:0];
    end

    always_ff @(posedge i_clock) begin
        if (state_q == S_IDLE && i_q_valid) begin
            qx_q    <= i_q_x;
            qy_q    <= i_q_y;
            qz_q    <= i_q_z;
            min_r_q <= i_min_radius;
            thr_q   <= i_threshold;
        end
        if (state_q == S_RADIUS) begin
            r2_q <= r2_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            q_ready_q    <= 1'b1;
            cand_ready_q <= 1'b0;
            res_valid_q  <= 1'b0;
            inlier_q     <= 1'b0;
            outlier_q    <= 1'b0;
            count_q      <= '0;
            rem_q        <= '0;
            drain_q      <= '0;
        end else begin
            count_q <= count_d;
            case (state_q)
                S_IDLE: begin
                    if (i_q_valid) begin
                        rem_q     <= i_cloud_size;
                        q_ready_q <= 1'b0;
                        state_q   <= S_RADIUS;
                    end
                end
                S_RADIUS: begin
                    if (rem_q == '0) begin
                        res_valid_q <= 1'b1;
                        inlier_q    <= (count_d >= thr_q);
                        outlier_q   <= !(count_d >= thr_q);
                        state_q     <= S_DONE;
                    end else begin
                        cand_ready_q <= 1'b1;
                        state_q      <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (beat_acc) begin
                        if (last_beat) begin
                            rem_q        <= '0;
                            cand_ready_q <= 1'b0;
                            drain_q      <= '0;
                            state_q      <= S_DRAIN;
                        end else begin
                            rem_q <= rem_q - CNT_W'(LANES);
                        end
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q + 2'd1;
                    // The last beat's matches land in count_d on the final drain edge.
                    if (drain_q == 2'(COMPARE_LAT - 1)) begin
                        res_valid_q <= 1'b1;
                        inlier_q    <= (count_d >= thr_q);
                        outlier_q   <= !(count_d >= thr_q);
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_res_ready) begin
                        count_q     <= '0;
                        res_valid_q <= 1'b0;
                        inlier_q    <= 1'b0;
                        outlier_q   <= 1'b0;
                        q_ready_q   <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_q_ready    = q_ready_q;
    assign o_cand_ready = cand_ready_q;
    assign o_res_valid  = res_valid_q;
    assign o_inlier     = inlier_q;
    assign o_outlier    = outlier_q;

`ifdef DROR_STATS_EN
    assign o_neighbor_count = res_valid_q ? count_q : '0;
`endif

endmodule

// File: tb/tb_dror_validator_stream.sv
// Bench for dror_validator_stream: randomized and directed queries checked against
// a behavioural neighbour-count model; a per-cycle process checks result outputs.
module tb_dror_validator_stream;

    localparam int N         = 16;
    localparam int LANES     = 8;
    localparam int CNT_W     = 16;
    localparam int ANG_SHIFT = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                q_valid = 1'b0;
    logic                q_ready;
    logic [N-1:0]        q_x = '0, q_y = '0, q_z = '0;
    logic [CNT_W-1:0]    cloud_size = '0, threshold = '0;
    logic [N-1:0]        min_radius = '0;
    logic                cand_valid = 1'b0;
    logic                cand_ready;
    logic [N*LANES-1:0]  cand_x = '0, cand_y = '0, cand_z = '0;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic                inlier, outlier;
`ifdef DROR_STATS_EN
    logic [CNT_W-1:0]    neighbor_count;
`endif

    int   errors = 0;
    int   checks = 0;
    logic exp_inlier = 1'b0;
    int   exp_count = 0;
    int   px[64], py[64], pz[64];

    always #5 clk = ~clk;

    dror_validator_stream #(
        .N(N), .LANES(LANES), .CNT_W(CNT_W), .ANG_SHIFT(ANG_SHIFT)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_q_valid    (q_valid),
        .o_q_ready    (q_ready),
        .i_q_x        (q_x),
        .i_q_y        (q_y),
        .i_q_z        (q_z),
        .i_cloud_size (cloud_size),
        .i_threshold  (threshold),
        .i_min_radius (min_radius),
        .i_cand_valid (cand_valid),
        .o_cand_ready (cand_ready),
        .i_cand_x     (cand_x),
        .i_cand_y     (cand_y),
        .i_cand_z     (cand_z),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_inlier     (inlier),
        .o_outlier    (outlier)
`ifdef DROR_STATS_EN
        ,
        .o_neighbor_count (neighbor_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint m_r2(input int qx, input int qy, input int mr);
        longint planar, minr;
        planar = (longint'(qx) * qx + longint'(qy) * qy) >>> (2 * ANG_SHIFT);
        minr   = longint'(mr) * mr;
        return (planar > minr) ? planar : minr;
    endfunction

    function automatic longint m_d2(input int ax, input int ay, input int az,
                                    input int bx, input int by, input int bz);
        return longint'(ax - bx) * (ax - bx) + longint'(ay - by) * (ay - by)
             + longint'(az - bz) * (az - bz);
    endfunction

    function automatic int m_count(input int qx, input int qy, input int qz,
                                   input int mr, input int cloud);
        int c = 0;
        longint r2 = m_r2(qx, qy, mr);
        for (int i = 0; i < cloud; i++) begin
            if (m_d2(qx, qy, qz, px[i], py[i], pz[i]) <= r2) c++;
        end
        return (c > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : c;
    endfunction

    // Result outputs are meaningful on every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                check("res_inlier", inlier, exp_inlier);
                check("res_outlier", outlier, !exp_inlier);
            end else begin
                check("flags_low_when_idle", {inlier, outlier}, 0);
            end
`ifdef DROR_STATS_EN
            check("stats_count", neighbor_count, res_valid ? exp_count : 0);
`endif
        end
    end

    task automatic drive_lanes(input int base, input int cloud, input int qx, input int qy, input int qz);
        for (int k = 0; k < LANES; k++) begin
            if (base + k < cloud) begin
                cand_x[k*N +: N] = N'(px[base + k]);
                cand_y[k*N +: N] = N'(py[base + k]);
                cand_z[k*N +: N] = N'(pz[base + k]);
            end else begin
                // Unused lanes carry the query itself, which would count if not masked.
                cand_x[k*N +: N] = N'(qx);
                cand_y[k*N +: N] = N'(qy);
                cand_z[k*N +: N] = N'(qz);
            end
        end
    endtask

    task automatic present_query(input int qx, input int qy, input int qz,
                                 input int mr, input int cloud, input int thr);
        int guard = 0;
        q_x = N'(qx); q_y = N'(qy); q_z = N'(qz);
        min_radius = N'(mr);
        cloud_size = CNT_W'(cloud);
        threshold  = CNT_W'(thr);
        q_valid = 1'b1;
        while (!q_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("q_ready_before_accept", q_ready, 1);
        @(posedge clk); #1;
        q_valid = 1'b0;
    endtask

    task automatic run_query(input int qx, input int qy, input int qz, input int mr,
                             input int cloud, input int thr, input int hold, input int lit);
        int idx, guard, waited;
        bit acc, saw_cand;
        exp_count  = m_count(qx, qy, qz, mr, cloud);
        exp_inlier = (exp_count >= thr);
        if (lit >= 0) check("model_vs_hand", exp_inlier, lit);
        present_query(qx, qy, qz, mr, cloud, thr);

        idx = 0; guard = 0;
        while (idx < cloud && guard < 400) begin
            drive_lanes(idx, cloud, qx, qy, qz);
            cand_valid = ($urandom_range(0, 3) != 0);
            acc = cand_valid && cand_ready;
            @(posedge clk); #1;
            if (acc) idx += (cloud - idx < LANES) ? cloud - idx : LANES;
            guard++;
        end
        cand_valid = 1'b0;
        check("beats_accepted", idx, cloud);

        waited = 0; saw_cand = 0;
        while (!res_valid && waited < 20) begin
            if (cand_ready) saw_cand = 1;
            @(posedge clk); #1;
            waited++;
        end
        check("res_valid_arrives", res_valid, 1);
        check("cand_ready_low_after_last", saw_cand, 0);
        if (cloud == 0) check("empty_cloud_within_3", waited <= 3, 1);
        if (lit >= 0) check("hand_inlier", inlier, lit);

        q_valid = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_res_valid", res_valid, 1);
            check("hold_q_not_ready", q_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        q_valid   = 1'b0;
        check("res_valid_drop", res_valid, 0);
        check("q_ready_back", q_ready, 1);
    endtask

    task automatic check_reset_values();
        check("rst_q_ready", q_ready, 1);
        check("rst_cand_ready", cand_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_inlier", inlier, 0);
        check("rst_outlier", outlier, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values();

        // Hand-computed pins on the model.
        check("pin_r2_range", m_r2(800, 0, 0), 10000);
        check("pin_r2_min", m_r2(0, 0, 2), 4);
        check("pin_d2_neg", m_d2(-5, -5, -5, 5, 5, 5), 300);

        // Three close points among far ones.
        for (int i = 0; i < 8; i++) begin
            px[i] = (i < 3) ? 1 : 100; py[i] = (i < 3) ? 1 : 0; pz[i] = 0;
        end
        check("pin_count_basic", m_count(0, 0, 0, 2, 8), 3);
        run_query(0, 0, 0, 2, 8, 3, 0, 1);
        // Same query with the consumer stalling for 10 cycles.
        run_query(0, 0, 0, 2, 8, 3, 10, 1);

        // Range-scaled radius with the exact boundary at dx=100.
        for (int i = 0; i < 20; i++) begin px[i] = 1300; py[i] = 0; pz[i] = 0; end
        px[2] = 900; px[9] = 900; px[13] = 900; px[17] = 900; px[5] = 901;
        check("pin_count_boundary", m_count(800, 0, 0, 0, 20), 4);
        run_query(800, 0, 0, 0, 20, 5, 0, 0);

        // Empty cloud.
        run_query(0, 0, 0, 0, 0, 1, 0, 0);
        run_query(0, 0, 0, 0, 0, 0, 0, 1);

        // Negative coordinates: d2 = 300 vs r2 = 324 and 289.
        px[0] = 5; py[0] = 5; pz[0] = 5;
        run_query(-5, -5, -5, 18, 1, 1, 0, 1);
        run_query(-5, -5, -5, 17, 1, 1, 0, 0);

        // Reset during the second beat of an all-neighbour query.
        for (int i = 0; i < 24; i++) begin px[i] = 10; py[i] = 10; pz[i] = 10; end
        present_query(10, 10, 10, 1, 24, 1);
        drive_lanes(0, 24, 10, 10, 10);
        cand_valid = 1'b1;
        guard = 0;
        while (!cand_ready && guard < 10) begin @(posedge clk); #1; guard++; end
        check("cand_ready_up", cand_ready, 1);
        @(posedge clk); #1;
        drive_lanes(8, 24, 10, 10, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cand_valid = 1'b0;
        check_reset_values();
        for (int i = 0; i < 8; i++) begin px[i] = 1000; py[i] = 0; pz[i] = 0; end
        run_query(10, 10, 10, 1, 8, 1, 0, 0);

        // Randomized queries; every fifth uses the full coordinate range.
        for (int t = 0; t < 30; t++) begin
            int qx, qy, qz, mr, cloud, thr;
            bit wide = (t % 5 == 0);
            qx = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 128)) - 64;
            qy = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 128)) - 64;
            qz = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 128)) - 64;
            mr = wide ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 20));
            cloud = int'($urandom_range(0, 30));
            thr   = int'($urandom_range(0, cloud + 1));
            for (int i = 0; i < cloud; i++) begin
                if (wide) begin
                    px[i] = int'($urandom_range(0, 65535)) - 32768;
                    py[i] = int'($urandom_range(0, 65535)) - 32768;
                    pz[i] = int'($urandom_range(0, 65535)) - 32768;
                end else begin
                    px[i] = qx + int'($urandom_range(0, 40)) - 20;
                    py[i] = qy + int'($urandom_range(0, 40)) - 20;
                    pz[i] = qz + int'($urandom_range(0, 40)) - 20;
                end
            end
            run_query(qx, qy, qz, mr, cloud, thr, int'($urandom_range(0, 3)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
